// File: rtl/output_display_pkg.sv
// Shared definitions for the output stage: control-word bits, seven-segment
// glyphs and conversion FSM states.
package output_display_pkg;

    typedef enum logic [3:0] {
        CW_HLT,
        CW_MEM_IN,
        CW_RAM_IN,
        CW_RAM_OUT,
        CW_INS_OUT,
        CW_INS_IN,
        CW_A_IN,
        CW_A_OUT,
        CW_ALU_OUT,
        CW_SUB,
        CW_B_IN,
        CW_OUT_IN,
        CW_PC_EN,
        CW_PC_OUT,
        CW_JUMP,
        CW_FLAGS_IN
    } cw_e;

    localparam int DISPLAY_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } conv_state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (nibble <= 4'd9) begin
            seg = SEG_DIGIT[nibble];
        end
        return seg;
    endfunction

endpackage

// File: rtl/output_display_bin2bcd8.sv
// Sequential double-dabble converter: 8-bit binary to 3-digit BCD in 8 clocks.
// done/bcd are combinational on the final iteration so the caller commits at that edge.
module bin2bcd8
    import output_display_pkg::*;
(
    input  logic        clk,
    input  logic        clear_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_e state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [2:0]  iter_q, iter_d;
    logic [19:0] adj;
    logic [19:0] shifted;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        adj = shift_q;
        for (int n = 0; n < 3; n++) begin
            if (shift_q[8 + 4*n +: 4] >= 4'd5) begin
                adj[8 + 4*n +: 4] = shift_q[8 + 4*n +: 4] + 4'd3;
            end
        end
        shifted = adj << 1;
    end

    // A new start always wins, so an interrupted conversion never signals done.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        done    = 1'b0;
        if (start) begin
            state_d = ST_CONV;
            shift_d = {12'b0, bin};
            iter_d  = '0;
        end else if (state_q == ST_CONV) begin
            shift_d = shifted;
            iter_d  = iter_q + 3'd1;
            if (iter_q == 3'd7) begin
                state_d = ST_IDLE;
                done    = 1'b1;
            end
        end
    end

    assign busy = (state_q == ST_CONV);
    assign bcd  = shifted[19:8];

endmodule

// File: rtl/output_display.sv
// Output register, BCD commit and 4-digit multiplexed seven-segment driver.
// Optional SIGNED_DISPLAY_EN adds signed_mode and a minus sign on digit 3.
module output_display
    import output_display_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        load,
    input  logic [7:0]  bus_in,
`ifdef SIGNED_DISPLAY_EN
    input  logic        signed_mode,
`endif
    output logic [7:0]  data_out,
    output logic [11:0] bcd_out,
    output logic        busy,
    output logic [3:0]  digit_sel,
    output logic [6:0]  segments
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DISPLAY_DIGITS);

    logic [7:0]       engine_bin;
    logic             engine_done;
    logic [11:0]      engine_bcd;
    logic [DIV_W-1:0] scan_div_q;
    logic [IDX_W-1:0] scan_idx_q;
    logic             show_sign;

`ifdef SIGNED_DISPLAY_EN
    logic negative;
    logic sign_pend_q;
    logic sign_flag_q;

    assign negative   = signed_mode & bus_in[7];
    assign engine_bin = negative ? (~bus_in + 8'd1) : bus_in;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sign_pend_q <= 1'b0;
            sign_flag_q <= 1'b0;
        end else begin
            if (load) begin
                sign_pend_q <= negative;
            end
            if (engine_done) begin
                sign_flag_q <= sign_pend_q;
            end
        end
    end

    assign show_sign = sign_flag_q;
`else
    assign engine_bin = bus_in;
    assign show_sign  = 1'b0;
`endif

    bin2bcd8 u_bin2bcd8 (
        .clk     (clk),
        .clear_n (clear_n),
        .start   (load),
        .bin     (engine_bin),
        .busy    (busy),
        .done    (engine_done),
        .bcd     (engine_bcd)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            data_out <= '0;
            bcd_out  <= '0;
        end else begin
            if (load) begin
                data_out <= bus_in;
            end
            if (engine_done) begin
                bcd_out <= engine_bcd;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            scan_div_q <= '0;
            scan_idx_q <= '0;
        end else if (scan_div_q == DIV_W'(SCAN_DIV - 1)) begin
            scan_div_q <= '0;
            scan_idx_q <= scan_idx_q + 1'b1;
        end else begin
            scan_div_q <= scan_div_q + 1'b1;
        end
    end

    // Leading zeros are blanked, but a zero tens digit under a nonzero hundreds is shown.
    always_comb begin
        segments = SEG_BLANK;
        case (scan_idx_q)
            2'd0: segments = seg_encode(bcd_out[3:0]);
            2'd1: if (bcd_out[11:4] != 8'd0) segments = seg_encode(bcd_out[7:4]);
            2'd2: if (bcd_out[11:8] != 4'd0) segments = seg_encode(bcd_out[11:8]);
            default: if (show_sign) segments = SEG_MINUS;
        endcase
    end

    assign digit_sel = ~(4'b0001 << scan_idx_q);

endmodule

// File: tb/tb_output_display.sv
// Directed bench for output_display: reset, conversions, restart, async clear,
// and the signed build when SIGNED_DISPLAY_EN is defined.
module tb_output_display;

    logic        clk;
    logic        clear_n;
    logic        load;
    logic [7:0]  bus_in;
    logic        signed_mode;
    logic [7:0]  data_out;
    logic [11:0] bcd_out;
    logic        busy;
    logic [3:0]  digit_sel;
    logic [6:0]  segments;

    int vectors;
    int miscompares;

    output_display #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .load      (load),
        .bus_in    (bus_in),
`ifdef SIGNED_DISPLAY_EN
        .signed_mode (signed_mode),
`endif
        .data_out  (data_out),
        .bcd_out   (bcd_out),
        .busy      (busy),
        .digit_sel (digit_sel),
        .segments  (segments)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ld, input logic [7:0] v, input logic sm);
        load        = ld;
        bus_in      = v;
        signed_mode = sm;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for the requested digit to be selected, then checks its glyph.
    task automatic checkDigit(input int idx, input logic [6:0] exp_seg, input string tag);
        logic [3:0] want;
        logic found;
        want  = ~(4'b0001 << idx);
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (digit_sel === want) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput({tag, "_sel"}, {15'd0, found}, 16'd1);
        checkOutput(tag, {9'd0, segments}, {9'd0, exp_seg});
    endtask

    task automatic loadValue(input logic [7:0] v, input logic sm);
        applyStimulus(1'b1, v, sm);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic waitCommit();
        for (int k = 0; k < 8; k++) tick();
    endtask

    initial begin
        logic seen255;
        vectors     = 0;
        miscompares = 0;
        clear_n     = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        #22;
        clear_n = 1'b1;
        #1;

        // Reset state
        checkOutput("rst_data_out", {8'd0, data_out}, 16'h0000);
        checkOutput("rst_bcd_out", {4'd0, bcd_out}, 16'h0000);
        checkOutput("rst_busy", {15'd0, busy}, 16'h0000);
        checkOutput("rst_digit_sel", {12'd0, digit_sel}, 16'h000E);
        checkOutput("rst_segments", {9'd0, segments}, 16'h003F);
        checkDigit(1, 7'b0000000, "rst_dig1");
        checkDigit(2, 7'b0000000, "rst_dig2");
        checkDigit(3, 7'b0000000, "rst_dig3");
        checkDigit(0, 7'b0111111, "rst_dig0");

        // 255: busy for exactly 8 edges
        loadValue(8'hFF, 1'b0);
        checkOutput("ff_data_out", {8'd0, data_out}, 16'h00FF);
        checkOutput("ff_busy_N", {15'd0, busy}, 16'h0001);
        for (int k = 1; k < 8; k++) begin
            tick();
            checkOutput("ff_busy_mid", {15'd0, busy}, 16'h0001);
        end
        checkOutput("ff_bcd_pre", {4'd0, bcd_out}, 16'h0000);
        tick();
        checkOutput("ff_busy_done", {15'd0, busy}, 16'h0000);
        checkOutput("ff_bcd", {4'd0, bcd_out}, 16'h0255);
        checkDigit(0, 7'b1101101, "ff_dig0");
        checkDigit(1, 7'b1101101, "ff_dig1");
        checkDigit(2, 7'b1011011, "ff_dig2");
        checkDigit(3, 7'b0000000, "ff_dig3");

        // 7: leading zeros blanked
        loadValue(8'd7, 1'b0);
        waitCommit();
        checkOutput("d7_bcd", {4'd0, bcd_out}, 16'h0007);
        checkDigit(0, 7'b0000111, "d7_dig0");
        checkDigit(1, 7'b0000000, "d7_dig1");
        checkDigit(2, 7'b0000000, "d7_dig2");

        // Restart: 255 aborted by 100 three cycles later
        seen255 = 1'b0;
        loadValue(8'd255, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 8'd100, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rs_data_out", {8'd0, data_out}, 16'h0064);
        for (int k = 1; k < 8; k++) begin
            tick();
            if (bcd_out === 12'h255) seen255 = 1'b1;
        end
        checkOutput("rs_bcd_hold", {4'd0, bcd_out}, 16'h0007);
        tick();
        checkOutput("rs_no255", {15'd0, seen255}, 16'h0000);
        checkOutput("rs_bcd", {4'd0, bcd_out}, 16'h0100);
        checkDigit(0, 7'b0111111, "rs_dig0");
        checkDigit(1, 7'b0111111, "rs_dig1");
        checkDigit(2, 7'b0000110, "rs_dig2");

        // Asynchronous clear during the 4th conversion cycle
        loadValue(8'd200, 1'b0);
        tick();
        tick();
        tick();
        clear_n = 1'b0;
        #2;
        checkOutput("clr_data_out", {8'd0, data_out}, 16'h0000);
        checkOutput("clr_bcd_out", {4'd0, bcd_out}, 16'h0000);
        checkOutput("clr_busy", {15'd0, busy}, 16'h0000);
        checkOutput("clr_digit_sel", {12'd0, digit_sel}, 16'h000E);
        checkOutput("clr_segments", {9'd0, segments}, 16'h003F);
        #2;
        clear_n = 1'b1;
        loadValue(8'd42, 1'b0);
        waitCommit();
        checkOutput("c42_bcd", {4'd0, bcd_out}, 16'h0042);
        checkOutput("c42_busy", {15'd0, busy}, 16'h0000);
        checkDigit(1, 7'b1100110, "c42_dig1");
        checkDigit(0, 7'b1011011, "c42_dig0");

`ifdef SIGNED_DISPLAY_EN
        loadValue(8'h80, 1'b1);
        checkOutput("s80_data_out", {8'd0, data_out}, 16'h0080);
        waitCommit();
        checkOutput("s80_bcd", {4'd0, bcd_out}, 16'h0128);
        checkDigit(3, 7'b1000000, "s80_dig3");
        checkDigit(2, 7'b0000110, "s80_dig2");

        loadValue(8'hFF, 1'b1);
        waitCommit();
        checkOutput("sff_bcd", {4'd0, bcd_out}, 16'h0001);
        checkDigit(3, 7'b1000000, "sff_dig3");
        checkDigit(1, 7'b0000000, "sff_dig1");
        checkDigit(2, 7'b0000000, "sff_dig2");
        checkDigit(0, 7'b0000110, "sff_dig0");

        loadValue(8'hFF, 1'b0);
        waitCommit();
        checkOutput("uff_bcd", {4'd0, bcd_out}, 16'h0255);
        checkDigit(3, 7'b0000000, "uff_dig3");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
